// File: rtl/param_simple_loop.sv
// -----------------------------------------------------------------------------
// param_simple_loop
//
// Loop accumulator behind ready/valid channels. A request (n, limit) is taken
// into a one-entry input register. When the loop engine is idle it pops that
// entry and steps an accumulator from n by STEP until the accumulator reaches
// limit (unsigned compare) or the next step would carry out of WIDTH bits. The
// final value, the number of increments performed (saturating) and a carry
// flag go into a one-entry output register that drives the result channel.
//
// One job runs at a time. One further request can wait in the input register
// while the engine is busy.
//
// Parameters
//   WIDTH   accumulator / n / limit width (>= 2)
//   STEP    increment per iteration (1 <= STEP < 2**WIDTH)
//   ITER_W  iteration counter width; counter saturates at all-ones
//
// Ports
//   clk                      clock, all state on posedge
//   rst                      synchronous active-high reset
//   loop__chan_req_n         start value
//   loop__chan_req_limit     termination threshold
//   loop__chan_req_vld       request valid
//   loop__chan_req_rdy       request accepted this cycle (combinational on vld)
//   loop__chan_result        final accumulator value
//   loop__chan_result_iters  increments performed (saturating)
//   loop__chan_result_ovf    1 = stopped because the next step would carry out
//   loop__chan_result_vld    result valid
//   loop__chan_result_rdy    sink ready
// -----------------------------------------------------------------------------
module param_simple_loop #(
    parameter int WIDTH  = 10,
    parameter int STEP   = 1,
    parameter int ITER_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  loop__chan_req_n,
    input  logic [WIDTH-1:0]  loop__chan_req_limit,
    input  logic              loop__chan_req_vld,
    output logic              loop__chan_req_rdy,
    output logic [WIDTH-1:0]  loop__chan_result,
    output logic [ITER_W-1:0] loop__chan_result_iters,
    output logic              loop__chan_result_ovf,
    output logic              loop__chan_result_vld,
    input  logic              loop__chan_result_rdy
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // STEP widened by one bit so the carry out of WIDTH is visible.
    localparam logic [WIDTH:0]  STEP_EXT = (WIDTH+1)'(STEP);
    localparam logic [ITER_W-1:0] ITER_ONE = ITER_W'(1);

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    state_t              state_reg, state_next;

    // input buffer
    logic                in_v_reg;
    logic [WIDTH-1:0]    in_n_reg;
    logic [WIDTH-1:0]    in_limit_reg;

    // loop engine
    logic [WIDTH-1:0]    acc_reg, acc_next;
    logic [WIDTH-1:0]    lim_reg, lim_next;
    logic [ITER_W-1:0]   cnt_reg, cnt_next;

    // output buffer
    logic                out_v_reg;
    logic [WIDTH-1:0]    res_reg;
    logic [ITER_W-1:0]   iters_reg;
    logic                ovf_reg;

    // ---------------------------------------------------------------------
    // Handshake glue
    // ---------------------------------------------------------------------
    logic                pop;
    logic                in_ld;
    logic                out_ld;
    logic                emit;
    logic                emit_ovf;

    // The buffered request leaves the input register the same cycle the
    // engine loads it, so a new request may be written into that cycle.
    assign pop    = (state_reg == ST_IDLE) && in_v_reg;
    assign in_ld  = !in_v_reg || pop;
    assign loop__chan_req_rdy = loop__chan_req_vld && in_ld;

    // The output register accepts a new result when empty or draining now.
    assign out_ld = loop__chan_result_rdy || !out_v_reg;

    // ---------------------------------------------------------------------
    // Datapath helpers
    // ---------------------------------------------------------------------
    logic [WIDTH:0]      sum_ext;
    logic                step_carry;
    logic                at_limit;
    logic [ITER_W-1:0]   cnt_sat;

    assign sum_ext    = {1'b0, acc_reg} + STEP_EXT;
    assign step_carry = sum_ext[WIDTH];
    assign at_limit   = (acc_reg >= lim_reg);
    assign cnt_sat    = (cnt_reg == {ITER_W{1'b1}}) ? cnt_reg : (cnt_reg + ITER_ONE);

    // ---------------------------------------------------------------------
    // FSM next state / datapath next values
    // ---------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        lim_next   = lim_reg;
        cnt_next   = cnt_reg;
        emit       = 1'b0;
        emit_ovf   = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                if (in_v_reg) begin
                    acc_next   = in_n_reg;
                    lim_next   = in_limit_reg;
                    cnt_next   = '0;
                    state_next = ST_RUN;
                end
            end

            ST_RUN: begin
                if (at_limit) begin
                    // Limit reached (also covers limit=0 and n>=limit).
                    emit = 1'b1;
                    if (out_ld) begin
                        state_next = ST_IDLE;
                    end
                end else if (step_carry) begin
                    // Next step would wrap: report the pre-add value.
                    emit     = 1'b1;
                    emit_ovf = 1'b1;
                    if (out_ld) begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    acc_next = sum_ext[WIDTH-1:0];
                    cnt_next = cnt_sat;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            in_v_reg     <= 1'b0;
            in_n_reg     <= '0;
            in_limit_reg <= '0;
            acc_reg      <= '0;
            lim_reg      <= '0;
            cnt_reg      <= '0;
            out_v_reg    <= 1'b0;
            res_reg      <= '0;
            iters_reg    <= '0;
            ovf_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            lim_reg   <= lim_next;
            cnt_reg   <= cnt_next;

            if (in_ld) begin
                in_v_reg <= loop__chan_req_vld;
                if (loop__chan_req_vld) begin
                    in_n_reg     <= loop__chan_req_n;
                    in_limit_reg <= loop__chan_req_limit;
                end
            end

            // A stalled emit keeps the FSM in RUN with acc/cnt unchanged,
            // so the same result is presented again until it is taken.
            if (out_ld) begin
                out_v_reg <= emit;
                if (emit) begin
                    res_reg   <= acc_reg;
                    iters_reg <= cnt_reg;
                    ovf_reg   <= emit_ovf;
                end
            end
        end
    end

    assign loop__chan_result       = res_reg;
    assign loop__chan_result_iters = iters_reg;
    assign loop__chan_result_ovf   = ovf_reg;
    assign loop__chan_result_vld   = out_v_reg;

endmodule
